// File: rtl/serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_tx_pkg
//
// Shared definitions for the serial transmit controller:
//   - tx_state_e : controller state encoding (IDLE, LOAD, SHIFT, PARITY).
//                  PARITY is only reachable when SERIAL_TX_CTRL_PARITY_EN is
//                  defined, but the encoding is always present so the state
//                  type is identical in every build.
//   - SR_FILL    : fill value shifted into the register LSB (drives sr_sin).
//   - cnt_width  : width of the bit counter for a given word width.
// -----------------------------------------------------------------------------
package serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_PARITY = 2'd3
  } tx_state_e;

  localparam logic SR_FILL = 1'b0;

  // $clog2 of the word width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_tx_ctrl_bit_counter.sv
// -----------------------------------------------------------------------------
// tx_bit_counter
//
// Up-counter that indexes the bit being shifted out of the current word.
//
// Parameters:
//   bit_size : word width; terminal count is bit_size-1.
//
// Ports:
//   clk   in  clock, rising edge
//   rstn  in  asynchronous active-low reset (counter -> 0)
//   clr_i in  synchronous clear (has priority over en_i)
//   en_i  in  count enable
//   tc_o  out terminal-count flag, high while the count equals bit_size-1
// -----------------------------------------------------------------------------
module tx_bit_counter
  import serial_tx_pkg::*;
#(
  parameter int unsigned bit_size = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = cnt_width(bit_size);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(bit_size - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == CNT_LAST);

  // Wrap to zero at terminal count so a non-power-of-two width never
  // leaves the counter parked outside its legal range.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx_ctrl.sv
// -----------------------------------------------------------------------------
// serial_tx_ctrl
//
// Control stage in front of a parallel-load shift register. Accepts words
// on a valid/ready handshake, loads them into the register, and presents the
// register MSB as a framed MSB-first serial stream.
//
// Build option:
//   SERIAL_TX_CTRL_PARITY_EN : when defined, each frame gets one trailing
//                              even-parity bit and ser_last moves onto it.
//
// Parameters:
//   bit_size : word width (>= 2); must match the attached shift register.
//
// Ports:
//   clk       in   clock, rising edge
//   rstn      in   asynchronous active-low reset
//   in_valid  in   upstream word valid
//   in_ready  out  word can be accepted this cycle
//   in_data   in   upstream word
//   sr_load   out  shift register parallel load
//   sr_sin    out  shift register serial input (constant fill)
//   sr_d      out  shift register parallel data (last accepted word)
//   sr_q      in   shift register contents fed back
//   ser_out   out  serial bit
//   ser_valid out  ser_out carries a frame bit this cycle
//   ser_last  out  final bit of the frame
//   busy      out  a frame is in progress
// -----------------------------------------------------------------------------
module serial_tx_ctrl
  import serial_tx_pkg::*;
#(
  parameter int unsigned bit_size = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bit_size-1:0] in_data,
  output logic                sr_load,
  output logic                sr_sin,
  output logic [bit_size-1:0] sr_d,
  input  logic [bit_size-1:0] sr_q,
  output logic                ser_out,
  output logic                ser_valid,
  output logic                ser_last,
  output logic                busy
);

  tx_state_e           state_q;
  tx_state_e           state_d;
  logic [bit_size-1:0] word_q;
  logic                accept;
  logic                frame_end;
  logic                tc;
  logic                cnt_clr;
  logic                cnt_en;

  // Only the MSB of the register is ever observed.
  logic                sr_q_unused;
  assign sr_q_unused = ^sr_q[bit_size-2:0];

  tx_bit_counter #(
    .bit_size (bit_size)
  ) u_bit_counter (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (tc)
  );

  assign cnt_clr = (state_q == ST_LOAD);
  assign cnt_en  = (state_q == ST_SHIFT);

`ifdef SERIAL_TX_CTRL_PARITY_EN
  logic par_bit;
  assign par_bit   = ^word_q;
  assign frame_end = (state_q == ST_PARITY);
`else
  assign frame_end = (state_q == ST_SHIFT) && tc;
`endif

  // Ready on the final bit of a frame lets the next word go straight to
  // LOAD, giving a single gap cycle between back-to-back frames.
  assign in_ready = (state_q == ST_IDLE) || frame_end;
  assign accept   = in_valid && in_ready;

  assign sr_sin = SR_FILL;
  assign sr_d   = word_q;
  assign busy   = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    sr_load   = 1'b0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sr_load = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_out   = sr_q[bit_size-1];
        ser_valid = 1'b1;
        if (tc) begin
`ifdef SERIAL_TX_CTRL_PARITY_EN
          state_d = ST_PARITY;
`else
          ser_last = 1'b1;
          state_d  = accept ? ST_LOAD : ST_IDLE;
`endif
        end
      end
      ST_PARITY: begin
`ifdef SERIAL_TX_CTRL_PARITY_EN
        ser_out   = par_bit;
        ser_valid = 1'b1;
        ser_last  = 1'b1;
        state_d   = accept ? ST_LOAD : ST_IDLE;
`else
        state_d   = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q <= '0;
    end else if (accept) begin
      word_q <= in_data;
    end
  end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
module tb_serial_tx_ctrl;

  localparam int BW = 8;
`ifdef SERIAL_TX_CTRL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          sr_load;
  logic          sr_sin;
  logic [BW-1:0] sr_d;
  logic [BW-1:0] sr_q;
  logic          ser_out;
  logic          ser_valid;
  logic          ser_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  serial_tx_ctrl #(.bit_size(BW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sr_load   (sr_load),
    .sr_sin    (sr_sin),
    .sr_d      (sr_d),
    .sr_q      (sr_q),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Parallel-load shift register (no reset), shifting toward the MSB.
  always_ff @(posedge clk) begin
    if (sr_load) sr_q <= sr_d;
    else         sr_q <= {sr_q[BW-2:0], sr_sin};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model: queue of future per-cycle outputs
  typedef struct packed {
    logic vld;
    logic bt;
    logic last;
    logic load;
  } rec_t;

  rec_t          q[$];
  logic [BW-1:0] model_d = '0;

  task automatic push_word(input logic [BW-1:0] d);
    rec_t r;
    r = '0; r.load = 1'b1;
    q.push_back(r);
    for (int i = 0; i < BW; i++) begin
      r = '0;
      r.vld  = 1'b1;
      r.bt   = d[BW-1-i];
      r.last = (i == BW - 1) && (PAR == 0);
      q.push_back(r);
    end
`ifdef SERIAL_TX_CTRL_PARITY_EN
    r = '0;
    r.vld  = 1'b1;
    r.bt   = (($countones(d) % 2) == 1);
    r.last = 1'b1;
    q.push_back(r);
`endif
  endtask

  // ---------------- per-sequence tallies
  int          cyc, nvalid, nlast, nload, nacc, last_idx, first_valid;
  logic [BW:0] coll;
  logic        s_acc;
  logic        vhist[$];
  logic        lhist[$];
  int          acc_cyc[$];

  task automatic clr_tally();
    cyc = 0; nvalid = 0; nlast = 0; nload = 0; nacc = 0;
    last_idx = -1; first_valid = -1; coll = '0;
    vhist.delete(); lhist.delete(); acc_cyc.delete();
  endtask

  task automatic step();
    rec_t e;
    logic m_ready;
    logic acc;
    @(negedge clk);
    e = (q.size() > 0) ? q[0] : '0;
    m_ready = (q.size() <= 1);
    chk("ser_valid", 32'(ser_valid), 32'(e.vld));
    chk("ser_out",   32'(ser_out),   32'(e.bt));
    chk("ser_last",  32'(ser_last),  32'(e.last));
    chk("sr_load",   32'(sr_load),   32'(e.load));
    chk("in_ready",  32'(in_ready),  32'(m_ready));
    chk("busy",      32'(busy),      32'(q.size() != 0));
    chk("sr_d",      32'(sr_d),      32'(model_d));
    chk("sr_sin",    32'(sr_sin),    32'(1'b0));
    vhist.push_back(ser_valid);
    lhist.push_back(ser_last);
    if (ser_valid) begin
      coll = {coll[BW-1:0], ser_out};
      nvalid++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (ser_last) begin nlast++; last_idx = nvalid - 1; end
    if (sr_load) nload++;
    acc = in_valid && m_ready;
    if (q.size() > 0) void'(q.pop_front());
    if (acc) begin
      push_word(in_data);
      model_d = in_data;
      nacc++;
      acc_cyc.push_back(cyc);
    end
    s_acc = acc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // ---------------- single-word vector table
  typedef struct {
    logic [BW-1:0] data;
    logic [BW-1:0] bits;
    logic          par;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{8'hA5, 8'b1010_0101, 1'b0};
    vt[1] = '{8'h07, 8'b0000_0111, 1'b1};
    vt[2] = '{8'h03, 8'b0000_0011, 1'b0};
    vt[3] = '{8'hFF, 8'b1111_1111, 1'b0};
    vt[4] = '{8'h00, 8'b0000_0000, 1'b0};
    vt[5] = '{8'h80, 8'b1000_0000, 1'b1};
    vt[6] = '{8'h01, 8'b0000_0001, 1'b1};
    vt[7] = '{8'h96, 8'b1001_0110, 1'b0};

    rstn = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready",  32'(in_ready),  32'(1'b1));
    chk("rst busy",      32'(busy),      32'(1'b0));
    chk("rst ser_valid", 32'(ser_valid), 32'(1'b0));
    chk("rst ser_last",  32'(ser_last),  32'(1'b0));
    chk("rst ser_out",   32'(ser_out),   32'(1'b0));
    chk("rst sr_load",   32'(sr_load),   32'(1'b0));
    chk("rst sr_d",      32'(sr_d),      32'(0));
    rstn = 1'b1;

    // Idle for 20 cycles.
    clr_tally();
    repeat (20) step();
    chk("idle valid count", 32'(nvalid), 32'(0));
    chk("idle load count",  32'(nload),  32'(0));

    // Table: one word at a time.
    for (int k = 0; k < 8; k++) begin
      logic [BW:0] exp_coll;
      exp_coll = (PAR != 0) ? {vt[k].bits, vt[k].par} : {1'b0, vt[k].bits};
      clr_tally();
      in_valid = 1'b1; in_data = vt[k].data;
      step();
      in_valid = 1'b0;
      repeat (BW + 4) step();
      chk($sformatf("vec%0d bits", k),     32'(coll),        32'(exp_coll));
      chk($sformatf("vec%0d nvalid", k),   32'(nvalid),      32'(BW + PAR));
      chk($sformatf("vec%0d last_idx", k), 32'(last_idx),    32'(BW - 1 + PAR));
      chk($sformatf("vec%0d nlast", k),    32'(nlast),       32'(1));
      chk($sformatf("vec%0d nload", k),    32'(nload),       32'(1));
      chk($sformatf("vec%0d latency", k),  32'(first_valid), 32'(2));
    end

    // Back-to-back 0xFF then 0x00 with in_valid held.
    clr_tally();
    in_valid = 1'b1; in_data = 8'hFF;
    step();
    in_data = 8'h00;
    for (int i = 0; i < 2 * BW + 10; i++) begin
      step();
      if (s_acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("b2b nvalid", 32'(nvalid), 32'(2 * (BW + PAR)));
    chk("b2b nlast",  32'(nlast),  32'(2));
    chk("b2b nload",  32'(nload),  32'(2));
    chk("b2b nacc",   32'(nacc),   32'(2));
    begin
      int li, gap, k2;
      li = -1; gap = 0;
      for (int i = 0; i < lhist.size(); i++)
        if (lhist[i] && li < 0) li = i;
      k2 = li + 1;
      while (k2 < vhist.size() && !vhist[k2]) begin gap++; k2++; end
      chk("b2b gap", 32'(gap), 32'(1));
      chk("b2b accept on last bit", 32'((acc_cyc.size() == 2) ? acc_cyc[1] : -1), 32'(li));
    end

    // in_valid pulse mid-frame is ignored.
    clr_tally();
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    in_valid = 1'b1; in_data = 8'hE7;
    step();
    in_valid = 1'b0;
    repeat (BW + 4) step();
    chk("pulse nload",  32'(nload),  32'(1));
    chk("pulse nlast",  32'(nlast),  32'(1));
    chk("pulse nvalid", 32'(nvalid), 32'(BW + PAR));
    chk("pulse sr_d",   32'(sr_d),   32'(8'h3C));

    // Reset on the 4th shift cycle of 0xC3, then send 0x81.
    clr_tally();
    in_valid = 1'b1; in_data = 8'hC3;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #1;
    chk("pre-reset valid", 32'(ser_valid), 32'(1'b1));
    #1 rstn = 1'b0;
    #1;
    chk("mid-rst ser_valid", 32'(ser_valid), 32'(1'b0));
    chk("mid-rst ser_last",  32'(ser_last),  32'(1'b0));
    chk("mid-rst ser_out",   32'(ser_out),   32'(1'b0));
    chk("mid-rst busy",      32'(busy),      32'(1'b0));
    chk("mid-rst in_ready",  32'(in_ready),  32'(1'b1));
    chk("mid-rst sr_load",   32'(sr_load),   32'(1'b0));
    chk("mid-rst sr_d",      32'(sr_d),      32'(0));
    chk("mid-rst no last",   32'(nlast),     32'(0));
    q.delete();
    model_d = '0;
    @(posedge clk);
    #1 rstn = 1'b1;
    clr_tally();
    in_valid = 1'b1; in_data = 8'h81;
    step();
    in_valid = 1'b0;
    repeat (BW + 4) step();
    chk("post-rst bits",
        32'(coll), 32'((PAR != 0) ? {8'h81, 1'b0} : {1'b0, 8'h81}));
    chk("post-rst nlast", 32'(nlast), 32'(1));

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = BW'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (BW + 4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_tx_ctrl.md
# serial_tx_ctrl

Control stage that sits directly upstream of the parallel-load shift register. It accepts parallel words over a valid/ready handshake and drives the register's `load`, `Sin` and `d` inputs. It then reads back the register's MSB and presents it as a framed, MSB-first serial stream with valid/last qualifiers. An optional even-parity bit can be appended after each word.

## Interface
- `bit_size`, default 8: word width; legal range ≥ 2. Must equal the attached shift register's `bit_size`.
- `clk`  input  1: single clock, rising edge.
- `rstn`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: upstream word valid.
- `in_ready`  output  1: block can accept a word this cycle.
- `in_data`  input  bit_size: upstream word.
- `sr_load`  output  1: drives the shift register `load`.
- `sr_sin`  output  1: drives the shift register `Sin`; constant 0 (fill value).
- `sr_d`  output  bit_size: drives the shift register `d`; holds the captured word.
- `sr_q`  input  bit_size: the shift register `q` fed back.
- `ser_out`  output  1: serial bit.
- `ser_valid`  output  1: `ser_out` is a valid bit this cycle.
- `ser_last`  output  1: final bit of the current frame.
- `busy`  output  1: a frame is in progress (state ≠ IDLE).

## Operation
- States:
  - IDLE: waiting for a word.
  - LOAD: `sr_load` = 1 for exactly one cycle.
  - SHIFT: `bit_size` cycles with `sr_load` = 0; register shifts MSB-ward.
  - PARITY: only when compiled in.
- Transfer rule: a word is accepted on any rising edge where `in_valid` && `in_ready`. The word is captured into `sr_d`, and the next state is LOAD.
- LOAD → SHIFT unconditionally. Bit counter is cleared to 0.
- SHIFT:
  - `ser_out` = `sr_q[bit_size-1]`, `ser_valid` = 1.
  - Counter increments each cycle; width is `$clog2(bit_size)`.
  - At count = `bit_size`-1 the word is done.
- End of word:
  - Without parity: `ser_last` = 1 on the count = `bit_size`-1 cycle. Next state is LOAD if a word is accepted that same cycle, else IDLE.
  - With parity: next state is PARITY.
- PARITY (one cycle):
  - `ser_out` = XOR of all `sr_d` bits (even parity); `ser_valid` = 1, `ser_last` = 1.
  - Next state is LOAD if a word is accepted that cycle, else IDLE.
- `in_ready` = 1 in IDLE and in the frame's final-bit cycle; 0 otherwise.
- `sr_d` changes only on an accepted transfer.
- Outputs of IDLE and LOAD: `ser_valid` = 0 and `ser_out` = 0. Stale shift-register contents are never exposed.
- `in_valid` without `in_ready`: ignored; the block does not latch it.
- Reset mid-frame: asynchronous return to IDLE. The in-flight word is discarded and no partial-frame `ser_last` is emitted. Shift register contents (unreset) are don't-care because `ser_valid` = 0.

## Timing
- Reset values: state IDLE, counter 0, `sr_d` 0, `sr_load` 0, `sr_sin` 0, `ser_out` 0, `ser_valid` 0, `ser_last` 0, `busy` 0, `in_ready` 1.
- Latency: transfer at edge E0 → LOAD in the cycle after E0 → MSB valid in the cycle after E1. That is 2 cycles from acceptance to the first `ser_valid`.
- Frame length: `bit_size` valid cycles (+1 with parity).
- Back-to-back: a word accepted on a last-bit cycle gives exactly one `ser_valid` = 0 gap cycle (LOAD). Period is `bit_size`+1 cycles (+2 with parity).
- All serial outputs are combinational from registered state and `sr_q`. No input-to-output combinational path exists except `in_ready` depending on state only.

## Configuration
- Macro: `SERIAL_TX_CTRL_PARITY_EN`.
- Defined: PARITY state exists, each frame gets one trailing even-parity bit, and `ser_last` moves to the parity bit.
- Undefined: PARITY state and the parity XOR are not generated, and frames are exactly `bit_size` bits.

## Structure
- Shared package `serial_tx_pkg`:
  - state encoding typedef (IDLE, LOAD, SHIFT, PARITY);
  - `SR_FILL` constant (1'b0) driven on `sr_sin`.
- One sub-module: `tx_bit_counter`, a parameterised up-counter with clear/enable and a terminal-count flag at `bit_size`-1. Everything else is flat in `serial_tx_ctrl`.
- The bench instantiates the existing shift register with matching `bit_size` wired to the `sr_*` ports.

## Test plan
- Reset then idle, `in_valid` = 0 → `in_ready` = 1; `busy`, `ser_valid` and `sr_load` = 0 for 20 cycles.
- `bit_size` = 8, send 0xA5 → `sr_load` high one cycle; `ser_out` = 1,0,1,0,0,1,0,1 on 8 consecutive `ser_valid` cycles; `ser_last` only on the 8th.
- Two words 0xFF then 0x00 back-to-back (`in_valid` held high) → second accepted on first frame's last bit; exactly one gap cycle; 16 valid bits total.
- Parity build, send 0x07 → 8 data bits then parity bit 1 with `ser_last`; send 0x03 → parity bit 0.
- Deassert `rstn` on the 4th shift cycle of 0xC3, release, send 0x81 → outputs clear immediately; no `ser_last` for 0xC3; 0x81 serialises intact.
- `in_valid` pulsed while `busy` and not on a last-bit cycle → pulse ignored; no extra frame.
